// File: rtl/pmp_access_arbiter_pkg.sv
// Shared types and constants for the PMP access arbiter.
//   arb_state_e : arbiter FSM states
//   pmp_req_t   : operands of one permission check (addr/oper/size/priv)
//   PMPCFG_BASE / PMPADDR_BASE : CSR addresses of pmpcfg0 and pmpaddr0
package pmp_access_arbiter_pkg;

    localparam int PMP_ADDR_W = 32;

    localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
    localparam logic [11:0] PMPADDR_BASE = 12'h3B0;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RESP,
        CSR_WR,
        CSR_ACK
    } arb_state_e;

    typedef struct packed {
        logic [PMP_ADDR_W-1:0] addr;
        logic [1:0]            oper;
        logic [1:0]            size;
        logic [1:0]            priv;
    } pmp_req_t;

endpackage

// File: rtl/pmp_access_arbiter_rr_arbiter.sv
// Round-robin request picker.
//   req       : request vector, one bit per port
//   ptr       : port with highest priority this cycle
//   grant_oh  : one-hot grant (first requesting port at or after ptr)
//   grant_idx : index of the granted port
//   grant_vld : any port granted
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!grant_vld && req[idx]) begin
                grant_vld     = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/pmp_access_arbiter.sv
// Shares one pmp_check between NUM_REQ requesters and serialises pmp_registers
// CSR writes against in-flight checks. One check in flight at a time.
//
// Ports
//   clk, reset                 clock, async active-high reset
//   req_valid/req_ready        per-port check request handshake
//   req_addr/oper/size/priv    per-port packed operands
//   rsp_valid/rsp_ready        per-port result handshake, rsp_perm shared
//   csr_wr_req/addr/data/ack   CSR write request (held until ack pulse)
//   chk_addr/oper/size/priv    registered operands to pmp_check
//   chk_permission             combinational result from pmp_check
//   reg_wr_en/reg_addr/wdata   write strobe and data to pmp_registers
//
// State   | Meaning
// IDLE    | pick CSR write or next check request
// CHECK   | operands presented to pmp_check, result sampled at end of cycle
// RESP    | rsp_valid held to the granted port until rsp_ready
// CSR_WR  | one-cycle reg_wr_en with captured address/data
// CSR_ACK | one-cycle csr_wr_ack
module pmp_access_arbiter
    import pmp_access_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = 32,
    parameter int CSR_ADDR_W = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*2-1:0]    req_oper,
    input  logic [NUM_REQ*2-1:0]    req_size,
    input  logic [NUM_REQ*2-1:0]    req_priv,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [1:0]              rsp_perm,
    input  logic                    csr_wr_req,
    input  logic [CSR_ADDR_W-1:0]   csr_wr_addr,
    input  logic [ADDR_W-1:0]       csr_wr_data,
    output logic                    csr_wr_ack,
    output logic [ADDR_W-1:0]       chk_addr,
    output logic [1:0]              chk_oper,
    output logic [1:0]              chk_size,
    output logic [1:0]              chk_priv,
    input  logic [1:0]              chk_permission,
    output logic                    reg_wr_en,
    output logic [CSR_ADDR_W-1:0]   reg_addr,
    output logic [ADDR_W-1:0]       reg_wdata
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e              state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]        grant_q, grant_d;
    logic                    csr_starve_q, csr_starve_d;
    pmp_req_t                chk_q, chk_d;
    logic [1:0]              rsp_perm_q, rsp_perm_d;
    logic [CSR_ADDR_W-1:0]   reg_addr_q, reg_addr_d;
    logic [ADDR_W-1:0]       reg_wdata_q, reg_wdata_d;

    pmp_req_t                req_vec [NUM_REQ];
    logic [NUM_REQ-1:0]      arb_oh;
    logic [PTR_W-1:0]        arb_idx;
    logic                    arb_vld;
    logic                    any_valid;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vec[i].addr = PMP_ADDR_W'(req_addr[i*ADDR_W +: ADDR_W]);
            req_vec[i].oper = req_oper[i*2 +: 2];
            req_vec[i].size = req_size[i*2 +: 2];
            req_vec[i].priv = req_priv[i*2 +: 2];
        end
    end

    assign any_valid = |req_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        csr_starve_d = csr_starve_q;
        chk_d        = chk_q;
        rsp_perm_d   = rsp_perm_q;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        req_ready    = '0;

        case (state_q)
            IDLE: begin
                // A starved check only beats the CSR write if one is actually waiting.
                if (csr_wr_req && (!csr_starve_q || !arb_vld)) begin
                    reg_addr_d  = csr_wr_addr;
                    reg_wdata_d = csr_wr_data;
                    state_d     = CSR_WR;
                end else if (arb_vld) begin
                    req_ready    = arb_oh;
                    grant_d      = arb_idx;
                    chk_d        = req_vec[arb_idx];
                    rr_ptr_d     = PTR_W'((int'(arb_idx) + 1) % NUM_REQ);
                    csr_starve_d = 1'b0;
                    state_d      = CHECK;
                end
            end
            CHECK: begin
                rsp_perm_d = chk_permission;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready[grant_q]) begin
                    state_d = IDLE;
                end
            end
            CSR_WR: begin
                if (any_valid) begin
                    csr_starve_d = 1'b1;
                end
                state_d = CSR_ACK;
            end
            CSR_ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            csr_starve_q <= 1'b0;
            chk_q        <= '0;
            rsp_perm_q   <= '0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            csr_starve_q <= csr_starve_d;
            chk_q        <= chk_d;
            rsp_perm_q   <= rsp_perm_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
        end
    end

    // Strobes decode straight from the state flop, so reset clears them asynchronously.
    assign rsp_valid  = (state_q == RESP) ? (NUM_REQ'(1) << grant_q) : '0;
    assign reg_wr_en  = (state_q == CSR_WR);
    assign csr_wr_ack = (state_q == CSR_ACK);

    assign rsp_perm  = rsp_perm_q;
    assign chk_addr  = ADDR_W'(chk_q.addr);
    assign chk_oper  = chk_q.oper;
    assign chk_size  = chk_q.size;
    assign chk_priv  = chk_q.priv;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_pmp_access_arbiter.sv
module tb_pmp_access_arbiter;
    import pmp_access_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int CW = 12;

    localparam int P_FREE  = 0;
    localparam int P_CHECK = 1;
    localparam int P_RESP  = 2;
    localparam int P_WRITE = 3;
    localparam int P_ACK   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*2-1:0]  req_oper, req_size, req_priv;
    logic [1:0]      rsp_perm;
    logic            csr_wr_req, csr_wr_ack;
    logic [CW-1:0]   csr_wr_addr, reg_addr;
    logic [AW-1:0]   csr_wr_data, reg_wdata, chk_addr;
    logic [1:0]      chk_oper, chk_size, chk_priv, chk_permission;
    logic            reg_wr_en;
    logic [1:0]      junk;

    int errors = 0;
    int checks = 0;

    pmp_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .CSR_ADDR_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_oper(req_oper), .req_size(req_size), .req_priv(req_priv),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_perm(rsp_perm),
        .csr_wr_req(csr_wr_req), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
        .csr_wr_ack(csr_wr_ack),
        .chk_addr(chk_addr), .chk_oper(chk_oper), .chk_size(chk_size), .chk_priv(chk_priv),
        .chk_permission(chk_permission),
        .reg_wr_en(reg_wr_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata)
    );

    always #5 clk = ~clk;

    // Stand-in pmp_check: permission is a simple function of address and access type.
    function automatic logic [1:0] perm_fn(input logic [31:0] a, input logic [1:0] op);
        return a[13:12] ^ op;
    endfunction

    assign chk_permission = perm_fn(chk_addr, chk_oper) ^ junk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase, n_phase, m_rr, m_port, e_g;
    bit          m_starve, e_found, e_wr, e_ack;
    logic [1:0]  m_perm, m_oper, m_size, m_priv;
    logic [31:0] m_addr, m_rdata;
    logic [11:0] m_raddr;
    logic [N-1:0] e_ready, e_rvalid;

    always @(negedge clk) begin
        if (reset) begin
            m_phase = P_FREE; m_rr = 0; m_starve = 0; m_port = 0; m_perm = '0;
            m_addr = '0; m_oper = '0; m_size = '0; m_priv = '0; m_raddr = '0; m_rdata = '0;
        end else begin
            check("m_chk_addr", chk_addr, m_addr);
            check("m_chk_ops", {chk_oper, chk_size, chk_priv}, {m_oper, m_size, m_priv});
            check("m_rsp_perm", rsp_perm, m_perm);
            check("m_reg_addr", reg_addr, m_raddr);
            check("m_reg_wdata", reg_wdata, m_rdata);
            e_ready = '0; e_rvalid = '0; e_wr = 0; e_ack = 0; e_found = 0; e_g = 0;
            n_phase = m_phase;
            case (m_phase)
                P_FREE: begin
                    if (csr_wr_req && (!m_starve || req_valid == '0)) begin
                        m_raddr = csr_wr_addr; m_rdata = csr_wr_data; n_phase = P_WRITE;
                    end else if (req_valid != '0) begin
                        for (int k = 0; k < N; k++) begin
                            if (!e_found && req_valid[(m_rr + k) % N]) begin
                                e_found = 1; e_g = (m_rr + k) % N;
                            end
                        end
                        e_ready[e_g] = 1'b1;
                        m_addr = req_addr[e_g*AW +: AW];
                        m_oper = req_oper[e_g*2 +: 2];
                        m_size = req_size[e_g*2 +: 2];
                        m_priv = req_priv[e_g*2 +: 2];
                        m_port = e_g; m_rr = (e_g + 1) % N; m_starve = 0;
                        n_phase = P_CHECK;
                    end
                end
                P_CHECK: begin
                    m_perm = perm_fn(m_addr, m_oper); n_phase = P_RESP;
                end
                P_RESP: begin
                    e_rvalid[m_port] = 1'b1;
                    if (rsp_ready[m_port]) n_phase = P_FREE;
                end
                P_WRITE: begin
                    e_wr = 1;
                    if (req_valid != '0) m_starve = 1;
                    n_phase = P_ACK;
                end
                default: begin
                    e_ack = 1; n_phase = P_FREE;
                end
            endcase
            check("m_req_ready", req_ready, e_ready);
            check("m_rsp_valid", rsp_valid, e_rvalid);
            check("m_reg_wr_en", reg_wr_en, e_wr);
            check("m_csr_ack", csr_wr_ack, e_ack);
            m_phase = n_phase;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int port, input logic [31:0] addr, input logic [1:0] oper);
        req_addr[port*AW +: AW] = addr;
        req_oper[port*2 +: 2]   = oper;
        req_size[port*2 +: 2]   = 2'b10;
        req_priv[port*2 +: 2]   = 2'b11;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {req_ready, rsp_valid, rsp_perm, csr_wr_ack, reg_wr_en,
                              chk_oper, chk_size, chk_priv, reg_addr}, 64'd0);
        check({tag, "_chk_addr"}, chk_addr, 64'd0);
        check({tag, "_wdata"}, reg_wdata, 64'd0);
    endtask

    // Called just after a rising edge with the arbiter idle and rsp_ready high.
    task automatic single_req(input int port, input logic [31:0] addr, input logic [1:0] oper,
                              input logic [1:0] exp_perm, input string tag);
        set_req(port, addr, oper);
        req_valid[port] = 1'b1;
        @(negedge clk); check({tag, "_ready"}, req_ready, 64'(1) << port);
        tick(); req_valid[port] = 1'b0;
        @(negedge clk); check({tag, "_rvalid_n1"}, rsp_valid, 64'd0);
        @(negedge clk); check({tag, "_rvalid_n2"}, rsp_valid, 64'(1) << port);
        check({tag, "_perm"}, rsp_perm, exp_perm);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants, g, found, wr_at, last, ack_at, nw, nc, changed;
        int waits [N];

        reset = 1'b1; req_valid = '0; rsp_ready = '1; req_addr = '0; req_oper = '0;
        req_size = '0; req_priv = '0; csr_wr_req = 1'b0; csr_wr_addr = '0; csr_wr_data = '0;
        junk = '0;

        // 1: reset values and single requests
        #2 check_all_zero("t1_in_reset");
        tick(); tick(); reset = 1'b0;
        @(negedge clk); check_all_zero("t1_after_reset");
        tick();
        single_req(0, 32'h0000_2FFF, 2'b00, 2'b10, "t1_p0");
        single_req(1, 32'h0000_2FFF, 2'b00, 2'b10, "t1_p1");

        // 2: both ports permanently valid
        set_req(0, 32'h0000_1000, 2'b00);
        set_req(1, 32'h0000_3000, 2'b01);
        req_valid = 2'b11;
        grants = 0; waits[0] = 0; waits[1] = 0;
        for (int c = 0; c < 80 && grants < 8; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g = req_ready[1] ? 1 : 0;
                check("t2_order", g, grants % 2);
                waits[g] = 0;
                waits[1-g]++;
                check("t2_starve", waits[1-g] > 1, 0);
                grants++;
            end
        end
        check("t2_grant_count", grants, 8);
        tick(); req_valid = '0;
        repeat (3) tick();

        // 3: CSR write arriving while port 1 stalls its response
        rsp_ready[1] = 1'b0;
        set_req(1, 32'h0000_1000, 2'b10);
        req_valid[1] = 1'b1;
        @(negedge clk); check("t3_ready", req_ready, 2'b10);
        tick(); req_valid[1] = 1'b0;
        csr_wr_req = 1'b1; csr_wr_addr = PMPADDR_BASE; csr_wr_data = 32'h0000_0BFF;
        @(negedge clk); check("t3_no_wr_check", reg_wr_en, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_stall_rvalid", rsp_valid, 2'b10);
            check("t3_stall_no_wr", reg_wr_en, 0);
        end
        tick(); rsp_ready[1] = 1'b1;
        @(negedge clk); check("t3_hs_rvalid", rsp_valid, 2'b10);
        check("t3_hs_perm", rsp_perm, 2'b11);
        wr_at = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (reg_wr_en) begin
                wr_at = c;
                check("t3_reg_addr", reg_addr, 12'h3B0);
                check("t3_reg_wdata", reg_wdata, 32'h0000_0BFF);
                break;
            end
        end
        check("t3_wr_delay", wr_at, 2);
        @(negedge clk); check("t3_ack", csr_wr_ack, 1);
        check("t3_wr_once", reg_wr_en, 0);
        tick(); csr_wr_req = 1'b0;
        @(negedge clk); check("t3_ack_pulse", csr_wr_ack, 0);
        tick();

        // 4: CSR request held high against a permanently valid port 0
        set_req(0, 32'h0000_2000, 2'b01);
        req_valid[0] = 1'b1;
        csr_wr_req = 1'b1; csr_wr_addr = PMPCFG_BASE; csr_wr_data = 32'h0000_001F;
        last = -1; ack_at = -100; nw = 0; nc = 0;
        for (int c = 0; c < 42; c++) begin
            @(negedge clk);
            if (reg_wr_en) begin
                check("t4_alt_w", last == 1, 0);
                last = 1; nw++;
            end
            if (csr_wr_ack) ack_at = c;
            if (req_ready[0]) begin
                check("t4_alt_c", last, 1);
                check("t4_grant_lat", (c - ack_at) <= 3, 1);
                last = 2; nc++;
            end
        end
        check("t4_writes", nw >= 5, 1);
        check("t4_checks", nc >= 5, 1);
        tick(); req_valid = '0; csr_wr_req = 1'b0;
        repeat (4) tick();

        // 5a: reset during CSR_WR
        csr_wr_req = 1'b1; csr_wr_addr = 12'h3A1; csr_wr_data = 32'h0000_0055;
        found = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (reg_wr_en) begin found = 1; break; end
        end
        check("t5_wr_seen", found, 1);
        #1 reset = 1'b1;
        #1 check_all_zero("t5_csr");
        tick(); csr_wr_req = 1'b0;
        @(negedge clk);
        tick(); reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); check("t5_no_ack", csr_wr_ack, 0);
        end
        tick();

        // 5b: reset during RESP
        rsp_ready[0] = 1'b0;
        set_req(0, 32'h0000_3FFF, 2'b00);
        req_valid[0] = 1'b1;
        @(negedge clk); check("t5_resp_ready", req_ready, 2'b01);
        tick(); req_valid[0] = 1'b0;
        found = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid[0]) begin found = 1; break; end
        end
        check("t5_resp_seen", found, 1);
        #1 reset = 1'b1;
        #1 check_all_zero("t5_resp");
        tick(); rsp_ready[0] = 1'b1;
        @(negedge clk);
        tick(); reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); check("t5_rvalid_dropped", rsp_valid, 0);
        end
        tick();
        single_req(0, 32'h0000_1000, 2'b00, 2'b01, "t5_after_p0");
        single_req(1, 32'h0000_3000, 2'b10, 2'b01, "t5_after_p1");

        // 6: result held while pmp_check output wanders
        rsp_ready[1] = 1'b0;
        set_req(1, 32'h0000_2FFF, 2'b00);
        req_valid[1] = 1'b1;
        @(negedge clk); check("t6_ready", req_ready, 2'b10);
        tick(); req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk); check("t6_rvalid", rsp_valid, 2'b10);
        check("t6_perm", rsp_perm, 2'b10);
        changed = 0;
        for (int k = 1; k <= 5; k++) begin
            tick(); junk = 2'(k);
            @(negedge clk);
            check("t6_hold", rsp_perm, 2'b10);
            check("t6_hold_rvalid", rsp_valid, 2'b10);
            if (chk_permission != 2'b10) changed++;
        end
        check("t6_chk_moved", changed > 0, 1);
        tick(); junk = '0; rsp_ready[1] = 1'b1;
        @(negedge clk); check("t6_hs", rsp_valid, 2'b10);
        tick();
        @(negedge clk); check("t6_done", rsp_valid, 0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
